alu_acc_ctrl: RTL and testbench

Sequencing and accumulator stage placed directly upstream of the 8-bit add/subtract ALU. It accepts operation commands over a valid/ready handshake, drives the ALU operand and select inputs from registered state, and captures the ALU result into an 8-bit accumulator. It returns each result with its flags over a second valid/ready handshake. It also keeps a sticky overflow flag and a completed-operation counter for downstream status logic.

---
 rtl/alu_acc_ctrl_pkg.sv | 21 ++
 rtl/alu_acc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_acc_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_acc_ctrl_pkg.sv
// alu_acc_ctrl_pkg
// Shared encodings for the accumulator sequencer: command op codes,
// FSM state encodings and the datapath width.
package alu_acc_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage : alu_acc_ctrl_pkg

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl
// Sequencer and accumulator stage placed directly upstream of an 8-bit
// add/subtract ALU. Takes commands over a valid/ready handshake, feeds the
// ALU from registered state, captures the result into the accumulator and
// returns it with flags over a second valid/ready handshake. Also keeps a
// sticky overflow flag and a count of completed responses.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   io_cmd_valid/ready     command handshake
//   io_cmd_op, io_cmd_data op code (LOAD/ADD/SUB/CLR) and operand
//   io_alu_a/b/sel         ALU operands and select (1 = subtract)
//   io_alu_result/overflow ALU outputs, sampled only in EXEC
//   io_alu_zero            not consumed; zero is computed locally
//   io_rsp_valid/ready     response handshake
//   io_rsp_result/overflow/zero  registered response fields
//   io_acc                 current accumulator
//   io_ovf_sticky          OR of response overflows since reset or CLR
//   io_op_count            completed responses, modulo 256
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | ready for a command (io_cmd_ready = 1)
// S_EXEC | one ALU evaluation cycle, inputs from registers only
// S_RESP | response held valid until io_rsp_ready
module alu_acc_ctrl
    import alu_acc_ctrl_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_cmd_valid,
    output logic         io_cmd_ready,
    input  logic [1:0]   io_cmd_op,
    input  logic [W-1:0] io_cmd_data,
    output logic [W-1:0] io_alu_a,
    output logic [W-1:0] io_alu_b,
    output logic         io_alu_sel,
    input  logic [W-1:0] io_alu_result,
    input  logic         io_alu_overflow,
    input  logic         io_alu_zero,
    output logic         io_rsp_valid,
    input  logic         io_rsp_ready,
    output logic [W-1:0] io_rsp_result,
    output logic         io_rsp_overflow,
    output logic         io_rsp_zero,
    output logic [W-1:0] io_acc,
    output logic         io_ovf_sticky,
    output logic [7:0]   io_op_count
);

    state_e        r_state;
    state_e        w_next_state;
    op_e           r_op;
    op_e           w_cmd_op;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_opnd;
    logic [W-1:0]  r_rsp_result;
    logic          r_rsp_ovf;
    logic          r_rsp_zero;
    logic          r_ovf_sticky;
    logic [7:0]    r_op_count;
    logic          w_cmd_fire;
    logic          w_rsp_fire;
    logic          w_unused;

    // The ALU's own zero flag is redundant with the local compare.
    assign w_unused = io_alu_zero;

    assign w_cmd_op = op_e'(io_cmd_op);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_fire   = 1'b0;
        w_rsp_fire   = 1'b0;
        io_cmd_ready = 1'b0;
        io_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                io_cmd_ready = 1'b1;
                if (io_cmd_valid) begin
                    w_cmd_fire = 1'b1;
                    if (w_cmd_op == OP_ADD || w_cmd_op == OP_SUB) begin
                        w_next_state = S_EXEC;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                io_rsp_valid = 1'b1;
                if (io_rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op         <= OP_ADD;
            r_opnd       <= '0;
            r_acc        <= '0;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_op   <= w_cmd_op;
                r_opnd <= io_cmd_data;
                case (w_cmd_op)
                    OP_LOAD: begin
                        r_acc        <= io_cmd_data;
                        r_rsp_result <= io_cmd_data;
                        r_rsp_ovf    <= 1'b0;
                        r_rsp_zero   <= (io_cmd_data == '0);
                    end
                    OP_CLR: begin
                        r_acc        <= '0;
                        r_rsp_result <= '0;
                        r_rsp_ovf    <= 1'b0;
                        r_rsp_zero   <= 1'b1;
                        r_ovf_sticky <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
            if (r_state == S_EXEC) begin
                r_acc        <= io_alu_result;
                r_rsp_result <= io_alu_result;
                r_rsp_ovf    <= io_alu_overflow;
                r_rsp_zero   <= (io_alu_result == '0);
            end
            // Command and response never fire on the same edge, so the
            // CLR clear above cannot collide with this update.
            if (w_rsp_fire) begin
                r_op_count   <= r_op_count + 8'd1;
                r_ovf_sticky <= r_ovf_sticky | r_rsp_ovf;
            end
        end
    end

    assign io_alu_a        = r_acc;
    assign io_alu_b        = r_opnd;
    assign io_alu_sel      = (r_op == OP_SUB);
    assign io_rsp_result   = r_rsp_result;
    assign io_rsp_overflow = r_rsp_ovf;
    assign io_rsp_zero     = r_rsp_zero;
    assign io_acc          = r_acc;
    assign io_ovf_sticky   = r_ovf_sticky;
    assign io_op_count     = r_op_count;

endmodule : alu_acc_ctrl

// File: tb/tb_alu_acc_ctrl.sv
module tb_alu_acc_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_cmd_valid = 1'b0;
    logic       io_cmd_ready;
    logic [1:0] io_cmd_op = 2'b00;
    logic [7:0] io_cmd_data = 8'h00;
    logic [7:0] io_alu_a;
    logic [7:0] io_alu_b;
    logic       io_alu_sel;
    logic [7:0] io_alu_result;
    logic       io_alu_overflow;
    logic       io_alu_zero;
    logic       io_rsp_valid;
    logic       io_rsp_ready = 1'b1;
    logic [7:0] io_rsp_result;
    logic       io_rsp_overflow;
    logic       io_rsp_zero;
    logic [7:0] io_acc;
    logic       io_ovf_sticky;
    logic [7:0] io_op_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference ALU beside the block: carry on add, signed overflow on sub.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, io_alu_a} + {1'b0, io_alu_b};
        if (io_alu_sel) begin
            io_alu_result   = io_alu_a - io_alu_b;
            io_alu_overflow = (io_alu_a[7] != io_alu_b[7]) && (io_alu_result[7] != io_alu_a[7]);
        end else begin
            io_alu_result   = alu_sum[7:0];
            io_alu_overflow = alu_sum[8];
        end
        io_alu_zero = ~io_alu_result[0]; // deliberately wrong; the block must ignore it
    end

    alu_acc_ctrl dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_op(io_cmd_op), .io_cmd_data(io_cmd_data),
        .io_alu_a(io_alu_a), .io_alu_b(io_alu_b), .io_alu_sel(io_alu_sel),
        .io_alu_result(io_alu_result), .io_alu_overflow(io_alu_overflow),
        .io_alu_zero(io_alu_zero),
        .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
        .io_rsp_result(io_rsp_result), .io_rsp_overflow(io_rsp_overflow),
        .io_rsp_zero(io_rsp_zero), .io_acc(io_acc),
        .io_ovf_sticky(io_ovf_sticky), .io_op_count(io_op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a command at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] d, output int acc_cyc);
        bit ok = 0;
        io_cmd_valid = 1'b1;
        io_cmd_op    = op;
        io_cmd_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (io_cmd_ready) begin ok = 1; break; end
            @(negedge clock);
        end
        if (!ok) chk("cmd_ready_timeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
        io_cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(input int acc_cyc, output int lat);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (io_rsp_valid) begin ok = 1; break; end
            @(negedge clock);
        end
        if (!ok) chk("rsp_valid_timeout", 0, 1);
        lat = cyc - acc_cyc + 1;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] res;
        logic       ovf;
        logic       zero;
        logic       sticky;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int acc_cyc, lat;
        int exp_cnt;

        vecs[0]  = '{2'b00, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{2'b10, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b01, 8'h7F, 8'h7E, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        chk("rst_cmd_ready", io_cmd_ready, 1);
        chk("rst_rsp_valid", io_rsp_valid, 0);
        chk("rst_rsp_result", io_rsp_result, 8'h00);
        chk("rst_rsp_ovf", io_rsp_overflow, 0);
        chk("rst_rsp_zero", io_rsp_zero, 0);
        chk("rst_sticky", io_ovf_sticky, 0);
        chk("rst_count", io_op_count, 8'h00);
        chk("rst_alu_sel", io_alu_sel, 0);
        chk("rst_acc", io_acc, 8'h00);
        chk("rst_alu_b", io_alu_b, 8'h00);

        exp_cnt = 0;
        foreach (vecs[i]) begin
            send_cmd(vecs[i].op, vecs[i].data, acc_cyc);
            if (vecs[i].op == 2'b01 || vecs[i].op == 2'b10) begin
                chk("exec_cmd_ready", io_cmd_ready, 0);
                chk("exec_rsp_valid", io_rsp_valid, 0);
                chk("exec_alu_sel", io_alu_sel, (vecs[i].op == 2'b10));
                chk("exec_alu_b", io_alu_b, vecs[i].data);
            end
            wait_rsp(acc_cyc, lat);
            chk("latency", lat, (vecs[i].op == 2'b01 || vecs[i].op == 2'b10) ? 2 : 1);
            chk("rsp_result", io_rsp_result, vecs[i].res);
            chk("rsp_ovf", io_rsp_overflow, vecs[i].ovf);
            chk("rsp_zero", io_rsp_zero, vecs[i].zero);
            chk("rsp_acc", io_acc, vecs[i].res);
            @(posedge clock);
            @(negedge clock);
            exp_cnt++;
            chk("count", io_op_count, exp_cnt);
            chk("sticky", io_ovf_sticky, vecs[i].sticky);
        end

        // Backpressure with a command waiting.
        send_cmd(2'b00, 8'h22, acc_cyc);
        wait_rsp(acc_cyc, lat);
        @(posedge clock);
        @(negedge clock);
        exp_cnt++;
        io_rsp_ready = 1'b0;
        send_cmd(2'b01, 8'h11, acc_cyc);
        wait_rsp(acc_cyc, lat);
        io_cmd_valid = 1'b1;
        io_cmd_op    = 2'b00;
        io_cmd_data  = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_rsp_valid", io_rsp_valid, 1);
            chk("bp_rsp_result", io_rsp_result, 8'h33);
            chk("bp_rsp_ovf", io_rsp_overflow, 0);
            chk("bp_cmd_ready", io_cmd_ready, 0);
            chk("bp_count", io_op_count, exp_cnt);
        end
        io_rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        exp_cnt++;
        chk("bp_no_same_edge_cmd", io_cmd_ready, 1);
        chk("bp_rsp_dropped", io_rsp_valid, 0);
        chk("bp_count_after", io_op_count, exp_cnt);
        @(posedge clock);
        @(negedge clock);
        io_cmd_valid = 1'b0;
        chk("bp_held_cmd_taken", io_rsp_valid, 1);
        chk("bp_held_cmd_result", io_rsp_result, 8'h5A);
        @(posedge clock);
        @(negedge clock);

        // Reset during EXEC.
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        send_cmd(2'b01, 8'h01, acc_cyc);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rx_cmd_ready", io_cmd_ready, 1);
        chk("rx_rsp_valid", io_rsp_valid, 0);
        chk("rx_acc", io_acc, 8'h00);
        chk("rx_count", io_op_count, 8'h00);
        chk("rx_alu_sel", io_alu_sel, 0);
        @(negedge clock);
        chk("rx_still_idle", io_rsp_valid, 0);

        for (int n = 1; n <= 256; n++) begin
            send_cmd(2'b00, n[7:0], acc_cyc);
            wait_rsp(acc_cyc, lat);
            @(posedge clock);
            @(negedge clock);
            if (n == 255) chk("count_ff", io_op_count, 8'hFF);
        end
        chk("count_wrap", io_op_count, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
